// File: rtl/prbs_pkg.sv
// Mode encoding, per-mode LFSR length/tap and state masks for the multi-polynomial PRBS generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS23 = 2'd2,
    MODE_PRBS31 = 2'd3
  } prbs_mode_e;

  localparam int unsigned STATE_W = 31;

  localparam int unsigned LEN_PRBS7  = 7;
  localparam int unsigned LEN_PRBS15 = 15;
  localparam int unsigned LEN_PRBS23 = 23;
  localparam int unsigned LEN_PRBS31 = 31;

  localparam int unsigned TAP_PRBS7  = 6;
  localparam int unsigned TAP_PRBS15 = 14;
  localparam int unsigned TAP_PRBS23 = 18;
  localparam int unsigned TAP_PRBS31 = 28;

  localparam logic [STATE_W-1:0] MASK_PRBS7  = 31'h0000_007F;
  localparam logic [STATE_W-1:0] MASK_PRBS15 = 31'h0000_7FFF;
  localparam logic [STATE_W-1:0] MASK_PRBS23 = 31'h007F_FFFF;
  localparam logic [STATE_W-1:0] MASK_PRBS31 = 31'h7FFF_FFFF;

  localparam logic [STATE_W-1:0] STATE_RST = 31'h7FFF_FFFF;

  // Doubles as the all-ones lockup-guard seed for the selected mode.
  function automatic logic [STATE_W-1:0] prbs_mask(input prbs_mode_e mode);
    logic [STATE_W-1:0] m;
    case (mode)
      MODE_PRBS7:  m = MASK_PRBS7;
      MODE_PRBS15: m = MASK_PRBS15;
      MODE_PRBS23: m = MASK_PRBS23;
      default:     m = MASK_PRBS31;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/prbs_lfsr_adv.sv
// Combinational DATA_W-step LFSR advance: produces one word (oldest bit at MSB) and the
// state after DATA_W steps for the selected polynomial.
module prbs_lfsr_adv
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [STATE_W-1:0] state,
  input  prbs_mode_e         mode,
  output logic [DATA_W-1:0]  word,
  output logic [STATE_W-1:0] state_nxt
);

  logic [STATE_W-1:0] s;
  logic               fb;

  always_comb begin
    word = '0;
    s    = state;
    fb   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      case (mode)
        MODE_PRBS7: begin
          word[DATA_W-1-i] = s[LEN_PRBS7-1];
          fb = s[LEN_PRBS7-1] ^ s[TAP_PRBS7-1];
        end
        MODE_PRBS15: begin
          word[DATA_W-1-i] = s[LEN_PRBS15-1];
          fb = s[LEN_PRBS15-1] ^ s[TAP_PRBS15-1];
        end
        MODE_PRBS23: begin
          word[DATA_W-1-i] = s[LEN_PRBS23-1];
          fb = s[LEN_PRBS23-1] ^ s[TAP_PRBS23-1];
        end
        default: begin
          word[DATA_W-1-i] = s[LEN_PRBS31-1];
          fb = s[LEN_PRBS31-1] ^ s[TAP_PRBS31-1];
        end
      endcase
      // Bits above N never reach the output; masking keeps the state canonical.
      s = {s[STATE_W-2:0], fb} & prbs_mask(mode);
    end
    state_nxt = s;
  end

endmodule

// File: rtl/prbs_gen_mp.sv
// Multi-polynomial PRBS generator (PRBS7/15/23/31), DATA_W bits per word, 1-cycle latency,
// valid/ready output held stable under backpressure. Optional bit-0 error inject: PRBS_ERR_INJ_EN.
module prbs_gen_mp
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [1:0]        mode_i,
  input  logic [30:0]       seed_i,
  input  logic              inj_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [CNT_W-1:0]  word_cnt_o
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_adv;
  logic [STATE_W-1:0] seed_mask;
  logic [STATE_W-1:0] seed_masked;
  logic [STATE_W-1:0] seed_load;
  prbs_mode_e         mode_q;
  logic [DATA_W-1:0]  word_adv;
  logic [DATA_W-1:0]  word_out;
  logic               produce;
  logic               accept;

  assign accept  = data_valid_o && data_ready_i;
  assign produce = en_i && (!data_valid_o || data_ready_i);

  assign seed_mask   = prbs_mask(prbs_mode_e'(mode_i));
  assign seed_masked = seed_i & seed_mask;
  assign seed_load   = (seed_masked == '0) ? seed_mask : seed_masked;

  prbs_lfsr_adv #(
    .DATA_W(DATA_W)
  ) u_adv (
    .state    (state_q),
    .mode     (mode_q),
    .word     (word_adv),
    .state_nxt(state_adv)
  );

`ifdef PRBS_ERR_INJ_EN
  localparam logic [DATA_W-1:0] INJ_BIT = DATA_W'(1);

  logic inj_q;
  logic inj_pend;

  // Only the word carries the error; state_q always advances from the clean LFSR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inj_q    <= 1'b0;
      inj_pend <= 1'b0;
    end else begin
      inj_q <= inj_i;
      if (load_i)
        inj_pend <= 1'b0;
      else if (produce && inj_pend)
        inj_pend <= 1'b0;
      else if (inj_i && !inj_q)
        inj_pend <= 1'b1;
    end
  end

  assign word_out = inj_pend ? (word_adv ^ INJ_BIT) : word_adv;
`else
  logic unused_inj;
  assign unused_inj = inj_i;
  assign word_out   = word_adv;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= STATE_RST;
      mode_q       <= MODE_PRBS15;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      word_cnt_o   <= '0;
    end else if (load_i) begin
      state_q      <= seed_load;
      mode_q       <= prbs_mode_e'(mode_i);
      data_valid_o <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      if (produce) begin
        data_o       <= word_out;
        data_valid_o <= 1'b1;
        state_q      <= state_adv;
      end else if (accept) begin
        data_valid_o <= 1'b0;
      end
      if (accept)
        word_cnt_o <= word_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs_gen_mp.sv
// Directed bench for prbs_gen_mp: hand-computed first words plus a bit-serial reference LFSR.
module tb_prbs_gen_mp;

  logic        clk;
  logic        rst_n;
  logic        en, load, inj, ready;
  logic [1:0]  mode;
  logic [30:0] seed;
  logic [15:0] data;
  logic        valid;
  logic [31:0] cnt;

  logic        en1, load1, inj1, ready1;
  logic [1:0]  mode1;
  logic [30:0] seed1;
  logic [0:0]  data1;
  logic        valid1;
  logic [3:0]  cnt1;

  int n_chk;
  int n_pass;

  logic [30:0] ms;
  int          mn;
  int          mt;

`ifdef PRBS_ERR_INJ_EN
  localparam logic [15:0] INJ_EXP = 16'hFE05;
`else
  localparam logic [15:0] INJ_EXP = 16'hFE04;
`endif

  prbs_gen_mp #(.DATA_W(16), .CNT_W(32)) u16 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .mode_i(mode), .seed_i(seed),
    .inj_i(inj), .data_o(data), .data_valid_o(valid), .data_ready_i(ready), .word_cnt_o(cnt)
  );

  prbs_gen_mp #(.DATA_W(1), .CNT_W(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .load_i(load1), .mode_i(mode1), .seed_i(seed1),
    .inj_i(inj1), .data_o(data1), .data_valid_o(valid1), .data_ready_i(ready1), .word_cnt_o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: emit MSB first, shift feedback into bit 0.
  function automatic logic [15:0] model_word(input logic [30:0] st, input int n, input int t,
                                             output logic [30:0] st_nxt);
    logic [15:0] w;
    logic [30:0] s;
    logic [30:0] m;
    logic        b;
    m = (31'h1 << n) - 31'h1;
    s = st & m;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[n-1];
      w = {w[14:0], b};
      s = ((s << 1) | {30'b0, b ^ s[t-1]}) & m;
    end
    st_nxt = s;
    return w;
  endfunction

  task automatic model_next(output logic [15:0] w);
    logic [30:0] nx;
    w  = model_word(ms, mn, mt, nx);
    ms = nx;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 0; load = 0; inj = 0; ready = 0; mode = 2'd0; seed = '0;
    en1 = 0; load1 = 0; inj1 = 0; ready1 = 0; mode1 = 2'd0; seed1 = '0;
    step; step;
    n_chk++;
    if (valid !== 1'b0 || data !== 16'h0 || cnt !== 32'h0)
      $display("FAIL reset_state: valid=%b data=%h cnt=%h want 0/0000/0", valid, data, cnt);
    else n_pass++;
    rst_n = 1'b1;
    en = 1; ready = 1;
    step;
    n_chk++;
    if (valid !== 1'b1 || data !== 16'hFFFE)
      $display("FAIL reset_default_prbs15: valid=%b data=%h want 1/fffe", valid, data);
    else n_pass++;
    en = 0;
  endtask

  task automatic test_prbs7_load;
    logic [15:0] w;
    load = 1; mode = 2'd0; seed = 31'h7F; en = 0; ready = 1;
    step;
    n_chk++;
    if (valid !== 1'b0 || cnt !== 32'h0)
      $display("FAIL load_clears: valid=%b cnt=%0d want 0/0", valid, cnt);
    else n_pass++;
    load = 0; en = 1;
    ms = 31'h7F; mn = 7; mt = 6;
    model_next(w);
    step;
    n_chk++;
    if (valid !== 1'b1 || data !== 16'hFE04 || cnt !== 32'h0)
      $display("FAIL prbs7_first: valid=%b data=%h cnt=%0d want 1/fe04/0", valid, data, cnt);
    else n_pass++;
    model_next(w);
    step;
    n_chk++;
    if (data !== w || cnt !== 32'h1)
      $display("FAIL prbs7_second: data=%h cnt=%0d want %h/1", data, cnt, w);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [15:0] hold;
    logic [15:0] w;
    logic [31:0] c;
    hold = data; c = cnt;
    ready = 0;
    for (int k = 0; k < 5; k++) begin
      step;
      n_chk++;
      if (valid !== 1'b1 || data !== hold || cnt !== c)
        $display("FAIL stall_hold: cyc=%0d valid=%b data=%h cnt=%0d want 1/%h/%0d",
                 k, valid, data, cnt, hold, c);
      else n_pass++;
    end
    ready = 1;
    model_next(w);
    step;
    n_chk++;
    if (data !== w || cnt !== c + 32'h1)
      $display("FAIL stall_resume: data=%h cnt=%0d want %h/%0d", data, cnt, w, c + 32'h1);
    else n_pass++;
  endtask

  task automatic test_idle;
    logic [15:0] w;
    en = 0;
    step;
    n_chk++;
    if (valid !== 1'b0)
      $display("FAIL idle_drop: valid=%b want 0", valid);
    else n_pass++;
    en = 1;
    model_next(w);
    step;
    n_chk++;
    if (valid !== 1'b1 || data !== w)
      $display("FAIL idle_resume: valid=%b data=%h want 1/%h", valid, data, w);
    else n_pass++;
  endtask

  task automatic test_load_zero_seed;
    logic [15:0] w;
    load = 1; mode = 2'd2; seed = 31'h0;
    step;
    n_chk++;
    if (valid !== 1'b0 || cnt !== 32'h0)
      $display("FAIL zero_seed_load: valid=%b cnt=%0d want 0/0", valid, cnt);
    else n_pass++;
    load = 0; mode = 2'd0;
    ms = 31'h7F_FFFF; mn = 23; mt = 18;
    model_next(w);
    step;
    n_chk++;
    if (data !== 16'hFFFF)
      $display("FAIL prbs23_first: data=%h want ffff", data);
    else n_pass++;
    model_next(w);
    step;
    n_chk++;
    if (data !== w)
      $display("FAIL prbs23_second: data=%h want %h", data, w);
    else n_pass++;
  endtask

  task automatic test_prbs31_guard;
    logic [15:0] w;
    load = 1; mode = 2'd0; seed = 31'h7FFF_FF80;
    step;
    load = 0;
    step;
    n_chk++;
    if (data !== 16'hFE04)
      $display("FAIL guard_high_bits: data=%h want fe04", data);
    else n_pass++;
    load = 1; mode = 2'd3; seed = 31'h2A5A_1234;
    step;
    load = 0;
    ms = 31'h2A5A_1234; mn = 31; mt = 28;
    for (int k = 0; k < 2; k++) begin
      model_next(w);
      step;
      n_chk++;
      if (data !== w)
        $display("FAIL prbs31_word%0d: data=%h want %h", k, data, w);
      else n_pass++;
    end
    en = 0;
  endtask

  task automatic test_prbs7_period;
    logic        seq [0:253];
    logic [30:0] st;
    logic [15:0] w;
    logic        ref_bits [0:127];
    int          mism;
    load1 = 1; mode1 = 2'd0; seed1 = 31'h55;
    step;
    load1 = 0; en1 = 1; ready1 = 1;
    for (int k = 0; k < 254; k++) begin
      step;
      seq[k] = data1[0];
    end
    en1 = 0;
    mism = 0;
    for (int i = 0; i < 127; i++)
      if (seq[i] !== seq[i+127]) mism++;
    n_chk++;
    if (mism != 0)
      $display("FAIL prbs7_period: %0d bits differ, want 0", mism);
    else n_pass++;
    st = 31'h55;
    for (int j = 0; j < 8; j++) begin
      w = model_word(st, 7, 6, st);
      for (int b = 0; b < 16; b++) ref_bits[j*16+b] = w[15-b];
    end
    mism = 0;
    for (int i = 0; i < 127; i++)
      if (seq[i] !== ref_bits[i]) mism++;
    n_chk++;
    if (mism != 0)
      $display("FAIL prbs7_serial: %0d bits differ from reference, want 0", mism);
    else n_pass++;
    n_chk++;
    if (cnt1 !== 4'd13)
      $display("FAIL cnt_wrap: cnt=%0d want 13", cnt1);
    else n_pass++;
  endtask

  task automatic test_inject;
    logic [15:0] w;
    load = 1; mode = 2'd0; seed = 31'h7F; en = 0; ready = 1;
    step;
    load = 0; inj = 1;
    step;
    inj = 0;
    step;
    en = 1;
    ms = 31'h7F; mn = 7; mt = 6;
    model_next(w);
    step;
    n_chk++;
    if (data !== INJ_EXP)
      $display("FAIL inject_word: data=%h want %h", data, INJ_EXP);
    else n_pass++;
    model_next(w);
    step;
    n_chk++;
    if (data !== w)
      $display("FAIL inject_next_clean: data=%h want %h", data, w);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    logic [15:0] w;
    en = 1; ready = 1;
    step;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (valid !== 1'b0 || data !== 16'h0 || cnt !== 32'h0)
      $display("FAIL async_reset: valid=%b data=%h cnt=%0d want 0/0000/0", valid, data, cnt);
    else n_pass++;
    step;
    rst_n = 1'b1;
    ms = 31'h7FFF; mn = 15; mt = 14;
    model_next(w);
    step;
    n_chk++;
    if (valid !== 1'b1 || data !== 16'hFFFE)
      $display("FAIL restart_first: valid=%b data=%h want 1/fffe", valid, data);
    else n_pass++;
    model_next(w);
    step;
    n_chk++;
    if (data !== w || cnt !== 32'h1)
      $display("FAIL restart_second: data=%h cnt=%0d want %h/1", data, cnt, w);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset;
    test_prbs7_load;
    test_backpressure;
    test_idle;
    test_load_zero_seed;
    test_prbs31_guard;
    test_prbs7_period;
    test_inject;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
